// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Cycles from request sampled in IDLE to the ack pulse, inclusive.
  localparam int unsigned ARB_LATENCY = 3;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bundle between one bus master and the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned address_size = 32
) ();

  logic                    req;
  logic                    we;
  logic [address_size-1:0] addr;
  logic [address_size-1:0] wdata;
  logic [address_size-1:0] rdata;
  logic                    ack;
  logic                    err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err
  );

endinterface

// File: rtl/rr_pick.sv
// Two-input round-robin selector: on a tie the requester not served last wins.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two masters onto one synchronous-read RAM with a fixed
// IDLE -> ACCESS -> RESP handshake; misaligned accesses never reach the RAM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned data_size    = 1024,
  parameter  int unsigned address_size = 32,
  localparam int unsigned AW           = $clog2(data_size)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  mem_arbiter_if.slave            m0,
  mem_arbiter_if.slave            m1,
  output logic [AW-1:0]           ram_addr,
  output logic                    ram_we,
  output logic [address_size-1:0] ram_wdata,
  input  logic [address_size-1:0] ram_rdata
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;

  logic       pick_grant;
  logic       pick_valid;

  rr_pick u_rr_pick (
    .req   ({m1.req, m0.req}),
    .last  (last_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Fields of the granted master; only meaningful in ACCESS/RESP.
  logic                    sel_we;
  logic [address_size-1:0] sel_addr;
  logic [address_size-1:0] sel_wdata;
  logic                    aligned;

  assign sel_we    = grant_q ? m1.we    : m0.we;
  assign sel_addr  = grant_q ? m1.addr  : m0.addr;
  assign sel_wdata = grant_q ? m1.wdata : m0.wdata;
  assign aligned   = word_aligned(sel_addr[1:0]);

  // Upper byte-address bits are dropped so addresses wrap over the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_addr[address_size-1:AW+2];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic                    ack0, ack1;
  logic                    resp_err;
  logic [address_size-1:0] resp_rdata;

  always_comb begin
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    unique case (state_q)
      ACCESS: begin
        ram_addr  = sel_addr[AW+1:2];
        ram_wdata = sel_wdata;
        ram_we    = sel_we & aligned;
      end
      RESP: begin
        ack0       = ~grant_q;
        ack1       = grant_q;
        resp_err   = ~aligned;
        resp_rdata = (!sel_we && aligned) ? ram_rdata : '0;
      end
      default: ;
    endcase
  end

  assign m0.ack   = ack0;
  assign m0.err   = ack0 & resp_err;
  assign m0.rdata = ack0 ? resp_rdata : '0;
  assign m1.ack   = ack1;
  assign m1.err   = ack1 & resp_err;
  assign m1.rdata = ack1 ? resp_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;

  localparam int unsigned DataSize = 1024;
  localparam int unsigned AddrSize = 32;
  localparam int unsigned AW       = $clog2(DataSize);

  logic                CLK;
  logic                RESET_N;
  logic [AW-1:0]       ram_addr;
  logic                ram_we;
  logic [AddrSize-1:0] ram_wdata;
  logic [AddrSize-1:0] ram_rdata;

  logic [AddrSize-1:0] mem [DataSize];

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.address_size(AddrSize)) m0_if ();
  mem_arbiter_if #(.address_size(AddrSize)) m1_if ();

  mem_arbiter #(
    .data_size    (DataSize),
    .address_size (AddrSize)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request fields must stay put while a request is outstanding.
  logic [64:0] p0, p1;
  logic        pr0 = 1'b0, pr1 = 1'b0, pa0 = 1'b0, pa1 = 1'b0;
  always @(negedge CLK) begin
    #1;
    if (RESET_N && pr0 && m0_if.req && !pa0)
      chk("m0_fields_stable", 32'(({m0_if.we, m0_if.addr, m0_if.wdata} === p0)), 32'd1);
    if (RESET_N && pr1 && m1_if.req && !pa1)
      chk("m1_fields_stable", 32'(({m1_if.we, m1_if.addr, m1_if.wdata} === p1)), 32'd1);
    p0  = {m0_if.we, m0_if.addr, m0_if.wdata};
    p1  = {m1_if.we, m1_if.addr, m1_if.wdata};
    pr0 = m0_if.req;
    pr1 = m1_if.req;
    pa0 = m0_if.ack;
    pa1 = m1_if.ack;
  end

  task automatic set_m0(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
  endtask

  initial begin
    logic e0, e1;
    RESET_N = 1'b0;
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < int'(DataSize); i++) mem[i] = '0;
    mem[5] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEF00D;

    // Reset state.
    @(negedge CLK);
    chk("rst_m0_ack", 32'(m0_if.ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_if.ack), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    RESET_N = 1'b1;

    // Single read of word 5.
    set_m0(1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge CLK);
    chk("rd_access_addr", 32'(ram_addr), 32'd5);
    chk("rd_access_we", 32'(ram_we), 32'd0);
    chk("rd_access_ack", 32'(m0_if.ack), 32'd0);
    @(negedge CLK);
    chk("rd_ack", 32'(m0_if.ack), 32'd1);
    chk("rd_rdata", m0_if.rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(m0_if.err), 32'd0);
    chk("rd_m1_ack", 32'(m1_if.ack), 32'd0);
    chk("rd_m1_rdata", m1_if.rdata, 32'h0);
    chk("rd_m1_err", 32'(m1_if.err), 32'd0);
    m0_if.req = 1'b0;
    @(negedge CLK);
    chk("rd_idle_ack", 32'(m0_if.ack), 32'd0);

    // m1 write then read of 0x40.
    set_m1(1'b1, 1'b1, 32'h40, 32'h12345678);
    @(negedge CLK);
    chk("wr_access_we", 32'(ram_we), 32'd1);
    chk("wr_access_addr", 32'(ram_addr), 32'd16);
    chk("wr_access_wdata", ram_wdata, 32'h12345678);
    @(negedge CLK);
    chk("wr_resp_we", 32'(ram_we), 32'd0);
    chk("wr_ack", 32'(m1_if.ack), 32'd1);
    chk("wr_err", 32'(m1_if.err), 32'd0);
    chk("wr_rdata", m1_if.rdata, 32'h0);
    chk("wr_mem16", mem[16], 32'h12345678);
    m1_if.req = 1'b0;
    @(negedge CLK);
    set_m1(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("wrrd_ack", 32'(m1_if.ack), 32'd1);
    chk("wrrd_rdata", m1_if.rdata, 32'h12345678);
    m1_if.req = 1'b0;
    @(negedge CLK);

    // Misaligned write never touches the RAM.
    set_m0(1'b1, 1'b1, 32'h13, 32'hAAAA5555);
    @(negedge CLK);
    chk("mis_access_we", 32'(ram_we), 32'd0);
    @(negedge CLK);
    chk("mis_ack", 32'(m0_if.ack), 32'd1);
    chk("mis_err", 32'(m0_if.err), 32'd1);
    chk("mis_rdata", m0_if.rdata, 32'h0);
    chk("mis_mem4", mem[4], 32'h0);
    m0_if.req = 1'b0;
    @(negedge CLK);
    chk("mis_idle_err", 32'(m0_if.err), 32'd0);

    // Address wrap: 0x1004 maps to word 1.
    set_m0(1'b1, 1'b0, 32'h1004, 32'h0);
    @(negedge CLK);
    chk("wrap_addr", 32'(ram_addr), 32'd1);
    @(negedge CLK);
    chk("wrap_ack", 32'(m0_if.ack), 32'd1);
    chk("wrap_rdata", m0_if.rdata, 32'hCAFEF00D);
    m0_if.req = 1'b0;
    @(negedge CLK);

    // Reset during ACCESS of a write aborts it.
    set_m0(1'b1, 1'b1, 32'h20, 32'h55AA55AA);
    @(negedge CLK);
    chk("rstmid_pre_we", 32'(ram_we), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("rstmid_we", 32'(ram_we), 32'd0);
    chk("rstmid_addr", 32'(ram_addr), 32'd0);
    m0_if.req = 1'b0;
    @(negedge CLK);
    chk("rstmid_ack_a", 32'(m0_if.ack), 32'd0);
    @(negedge CLK);
    chk("rstmid_ack_b", 32'(m0_if.ack), 32'd0);
    chk("rstmid_mem8", mem[8], 32'h0);

    // Contention from reset: m0 first, then strict alternation.
    set_m0(1'b1, 1'b0, 32'h14, 32'h0);
    set_m1(1'b1, 1'b0, 32'h40, 32'h0);
    RESET_N = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      e0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
      e1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
      chk($sformatf("cont_m0_ack_c%0d", k), 32'(m0_if.ack), 32'(e0));
      chk($sformatf("cont_m1_ack_c%0d", k), 32'(m1_if.ack), 32'(e1));
      chk($sformatf("cont_m0_rdata_c%0d", k), m0_if.rdata, e0 ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("cont_m1_rdata_c%0d", k), m1_if.rdata, e1 ? 32'h12345678 : 32'h0);
    end
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
